alu: RTL and testbench
======================

# alu

Execute-stage ALU of the 16-bit single-issue WISC processor. Decodes the 5-bit opcode and 2-bit funct and computes one 16-bit result:
- arithmetic, logic, shift and rotate ops;
- set/compare and branch-condition ops;
- memory address generation;
- immediate loads and link-PC pass-through.

Result is registered, one cycle after operands are presented; it feeds the writeback mux, the branch-resolve logic and the data-memory address port.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge active
- rst_n  in  1  synchronous active-low reset
- OpCode  in  5  instruction opcode, bits [15:11]
- funct  in  2  R-format function field; ignored by all other opcodes
- Rs  in  16  first source operand
- Rt  in  16  second source operand
- Pc  in  16  PC+2 value for link writes
- Imm  in  8  raw immediate, instruction bits [7:0]; only [4:0] used for 5-bit forms
- res  out  16  registered result

## Operation
Immediate extensions:
- sImm5 = sign-extend Imm[4:0]
- zImm5 = zero-extend Imm[4:0]
- sImm8 = sign-extend Imm[7:0]

Signed ops treat operands as 2's complement. All arithmetic is mod 2^16 unless noted.

Opcode map (next res):
- 01000 SUBI: sImm5 − Rs
- 01001 ADDI: Rs + sImm5
- 01010 ANDNI: Rs & ~zImm5
- 01011 XORI: Rs ^ zImm5
- 10100 ROLI: rotate Rs left by Imm[3:0]
- 10101 SLLI: Rs << Imm[3:0]
- 10110 RORI: rotate Rs right by Imm[3:0]
- 10111 SRLI: Rs >> Imm[3:0], logical
- 10000 ST, 10001 LD, 10011 STU: Rs + sImm5 (address)
- 11001 BTR: bit reverse of Rs; res[i] = Rs[15−i]
- 11011 by funct:
  - 00 ADD: Rs + Rt
  - 01 SUB: Rt − Rs
  - 10 XOR: Rs ^ Rt
  - 11 ANDN: Rs & ~Rt
- 11010 by funct, shift amount Rt[3:0]:
  - 00 ROL
  - 01 SLL
  - 10 ROR
  - 11 SRL
- 11100 SEQ: 1 if Rs == Rt
- 11101 SLT: 1 if Rs < Rt, signed
- 11110 SLE: 1 if Rs <= Rt, signed
- 11111 SCO: carry-out bit 16 of the 17-bit unsigned sum Rs + Rt
- 01100 BNEZ: 1 if Rs != 0
- 01101 BEQZ: 1 if Rs == 0
- 01110 BLTZ: 1 if Rs[15] == 1
- 01111 BGEZ: 1 if Rs[15] == 0
- 11000 LBI: sImm8
- 10010 SLBI: (Rs << 8) | Imm
- 00110, 00111 (JAL/JALR link): Pc
- Any other opcode: 16'h0000

Further rules:
- Compare and condition results are 16'h0001 or 16'h0000.
- Rotate or shift by 0 returns Rs unchanged.
- Only the low 4 bits of the shift amount are used; amount 16 is unreachable.

## Timing
- On each rising clk edge: if rst_n == 0, res ← 16'h0000; else res ← f(OpCode, funct, Rs, Rt, Pc, Imm) sampled at that edge.
- Latency is exactly 1 cycle, with a new op every cycle and no handshake or stall.
- Reset dominates any operation presented in the same cycle.
- Reset mid-stream discards the pending result; the first valid res is one cycle after rst_n returns high.
- No internal state other than the res register.

## Configuration
- ALU_BTR_EN defined: BTR (11001) is implemented as specified.
- ALU_BTR_EN undefined: the BTR datapath is omitted and opcode 11001 yields 16'h0000 like any unmapped opcode.

## Test plan
- Reset: rst_n=0 with ADD Rs=5, Rt=7 → res=0x0000; release rst_n → next edge res=0x000C.
- Arithmetic:
  - SUBI Rs=3, Imm=0x1F → 0xFFFC
  - SUB Rs=2, Rt=9 → 0x0007
  - SCO Rs=0xFFFF, Rt=0x0001 → 0x0001
- Shifts (Rs=0x8001, amount 4):
  - ROL → 0x0018
  - ROR → 0x1800
  - SLLI → 0x0010
  - SRL → 0x0800
- Compare and condition:
  - SLT Rs=0xFFFF, Rt=0x0001 → 1
  - SLE with Rs==Rt → 1
  - BLTZ Rs=0x8000 → 1
  - BGEZ Rs=0x8000 → 0
- Immediates:
  - LBI Imm=0x80 → 0xFF80
  - SLBI Rs=0x12AB, Imm=0xCD → 0xABCD
  - JAL with Pc=0x1234 → 0x1234
  - LD Rs=0x0100, Imm=0x10 → 0x00F0
- BTR Rs=0x0001 → 0x8000 with ALU_BTR_EN defined; 0x0000 without it. Unmapped opcode 00000 → 0x0000.

Source files
------------

// File: rtl/alu.sv
// Execute-stage ALU for the 16-bit WISC core: one registered 16-bit result per cycle.
// Build option: define ALU_BTR_EN to include the bit-reverse (BTR) datapath.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  OpCode,
  input  logic [1:0]  funct,
  input  logic [15:0] Rs,
  input  logic [15:0] Rt,
  input  logic [15:0] Pc,
  input  logic [7:0]  Imm,
  output logic [15:0] res
);

  typedef enum logic [4:0] {
    OP_JAL   = 5'b00110,
    OP_JALR  = 5'b00111,
    OP_SUBI  = 5'b01000,
    OP_ADDI  = 5'b01001,
    OP_ANDNI = 5'b01010,
    OP_XORI  = 5'b01011,
    OP_BNEZ  = 5'b01100,
    OP_BEQZ  = 5'b01101,
    OP_BLTZ  = 5'b01110,
    OP_BGEZ  = 5'b01111,
    OP_ST    = 5'b10000,
    OP_LD    = 5'b10001,
    OP_SLBI  = 5'b10010,
    OP_STU   = 5'b10011,
    OP_ROLI  = 5'b10100,
    OP_SLLI  = 5'b10101,
    OP_RORI  = 5'b10110,
    OP_SRLI  = 5'b10111,
    OP_LBI   = 5'b11000,
    OP_BTR   = 5'b11001,
    OP_RSH   = 5'b11010,
    OP_RARI  = 5'b11011,
    OP_SEQ   = 5'b11100,
    OP_SLT   = 5'b11101,
    OP_SLE   = 5'b11110,
    OP_SCO   = 5'b11111
  } op_e;

  logic [15:0] simm5, zimm5, simm8;
  logic [3:0]  sh;
  logic [31:0] dbl, rl, rr;
  logic [15:0] rol, ror, sll, srl;
  logic [16:0] sum17;
  logic [15:0] btr;
  logic [15:0] nxt;

  assign simm5 = {{11{Imm[4]}}, Imm[4:0]};
  assign zimm5 = {11'b0, Imm[4:0]};
  assign simm8 = {{8{Imm[7]}}, Imm};

  // One shifter serves both the immediate and register shift forms;
  // rotates come from shifting the operand concatenated with itself.
  assign sh  = (OpCode == OP_RSH) ? Rt[3:0] : Imm[3:0];
  assign dbl = {Rs, Rs};
  assign rl  = dbl << sh;
  assign rr  = dbl >> sh;
  assign rol = rl[31:16];
  assign ror = rr[15:0];
  assign sll = Rs << sh;
  assign srl = Rs >> sh;

  assign sum17 = {1'b0, Rs} + {1'b0, Rt};

`ifdef ALU_BTR_EN
  always_comb begin
    btr = '0;
    for (int unsigned i = 0; i < 16; i++) btr[i] = Rs[15 - i];
  end
`else
  assign btr = '0;
`endif

  always_comb begin
    nxt = '0;
    case (OpCode)
      OP_SUBI:  nxt = simm5 - Rs;
      OP_ADDI:  nxt = Rs + simm5;
      OP_ANDNI: nxt = Rs & ~zimm5;
      OP_XORI:  nxt = Rs ^ zimm5;
      OP_ROLI:  nxt = rol;
      OP_SLLI:  nxt = sll;
      OP_RORI:  nxt = ror;
      OP_SRLI:  nxt = srl;
      OP_ST, OP_LD, OP_STU: nxt = Rs + simm5;
      OP_BTR:   nxt = btr;
      OP_RARI: begin
        case (funct)
          2'b00:   nxt = sum17[15:0];
          2'b01:   nxt = Rt - Rs;
          2'b10:   nxt = Rs ^ Rt;
          default: nxt = Rs & ~Rt;
        endcase
      end
      OP_RSH: begin
        case (funct)
          2'b00:   nxt = rol;
          2'b01:   nxt = sll;
          2'b10:   nxt = ror;
          default: nxt = srl;
        endcase
      end
      OP_SEQ:   nxt = {15'b0, Rs == Rt};
      OP_SLT:   nxt = {15'b0, $signed(Rs) < $signed(Rt)};
      OP_SLE:   nxt = {15'b0, $signed(Rs) <= $signed(Rt)};
      OP_SCO:   nxt = {15'b0, sum17[16]};
      OP_BNEZ:  nxt = {15'b0, Rs != 16'h0000};
      OP_BEQZ:  nxt = {15'b0, Rs == 16'h0000};
      OP_BLTZ:  nxt = {15'b0, Rs[15]};
      OP_BGEZ:  nxt = {15'b0, ~Rs[15]};
      OP_LBI:   nxt = simm8;
      OP_SLBI:  nxt = {Rs[7:0], Imm};
      OP_JAL, OP_JALR: nxt = Pc;
      default:  nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) res <= '0;
    else        res <= nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for alu: expected results queued at issue, checked one cycle later.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  OpCode;
  logic [1:0]  funct;
  logic [15:0] Rs, Rt, Pc;
  logic [7:0]  Imm;
  logic [15:0] res;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  alu dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct),
    .Rs(Rs), .Rt(Rt), .Pc(Pc), .Imm(Imm), .res(res)
  );

  always #5 clk = ~clk;

  task automatic issue(input string tag, input logic rn, input logic [4:0] op,
                       input logic [1:0] f, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [15:0] pc, input logic [7:0] imm, input logic [15:0] exp);
    logic [15:0] e;
    string t;
    rst_n = rn; OpCode = op; funct = f; Rs = rs; Rt = rt; Pc = pc; Imm = imm;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (res === e) else begin
      failures++;
      $error("FAIL %s: res=%h expected=%h", t, res, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; OpCode = '0; funct = '0; Rs = '0; Rt = '0; Pc = '0; Imm = '0;
    #1;
    issue("reset_add",   1'b0, 5'b11011, 2'b00, 16'h0005, 16'h0007, 16'h0000, 8'h00, 16'h0000);
    issue("post_reset",  1'b1, 5'b11011, 2'b00, 16'h0005, 16'h0007, 16'h0000, 8'h00, 16'h000C);
    issue("subi",        1'b1, 5'b01000, 2'b00, 16'h0003, 16'h0000, 16'h0000, 8'h1F, 16'hFFFC);
    issue("addi_funct",  1'b1, 5'b01001, 2'b11, 16'h0010, 16'h1234, 16'h0000, 8'h1E, 16'h000E);
    issue("andni",       1'b1, 5'b01010, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 8'h15, 16'hFFEA);
    issue("xori",        1'b1, 5'b01011, 2'b00, 16'h00F0, 16'h0000, 16'h0000, 8'hFF, 16'h00EF);
    issue("sub",         1'b1, 5'b11011, 2'b01, 16'h0002, 16'h0009, 16'h0000, 8'h00, 16'h0007);
    issue("xor",         1'b1, 5'b11011, 2'b10, 16'hA5A5, 16'hFFFF, 16'h0000, 8'h00, 16'h5A5A);
    issue("andn",        1'b1, 5'b11011, 2'b11, 16'hF0F0, 16'hFF00, 16'h0000, 8'h00, 16'h00F0);
    issue("sco_carry",   1'b1, 5'b11111, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 8'h00, 16'h0001);
    issue("sco_nocarry", 1'b1, 5'b11111, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 8'h00, 16'h0000);
    issue("rol",         1'b1, 5'b11010, 2'b00, 16'h8001, 16'h0004, 16'h0000, 8'h00, 16'h0018);
    issue("sll",         1'b1, 5'b11010, 2'b01, 16'h8001, 16'h0004, 16'h0000, 8'h00, 16'h0010);
    issue("ror_hi_amt",  1'b1, 5'b11010, 2'b10, 16'h8001, 16'h0014, 16'h0000, 8'h00, 16'h1800);
    issue("srl",         1'b1, 5'b11010, 2'b11, 16'h8001, 16'h0004, 16'h0000, 8'h00, 16'h0800);
    issue("srl_zero",    1'b1, 5'b11010, 2'b11, 16'h8001, 16'h0000, 16'h0000, 8'h00, 16'h8001);
    issue("roli_zero",   1'b1, 5'b10100, 2'b00, 16'h8001, 16'h0000, 16'h0000, 8'h00, 16'h8001);
    issue("roli",        1'b1, 5'b10100, 2'b00, 16'h8001, 16'h0000, 16'h0000, 8'hF4, 16'h0018);
    issue("slli",        1'b1, 5'b10101, 2'b00, 16'h8001, 16'h0000, 16'h0000, 8'h04, 16'h0010);
    issue("rori_15",     1'b1, 5'b10110, 2'b00, 16'h8001, 16'h0000, 16'h0000, 8'h0F, 16'h0003);
    issue("srli",        1'b1, 5'b10111, 2'b00, 16'h8001, 16'h0000, 16'h0000, 8'h04, 16'h0800);
    issue("seq_eq",      1'b1, 5'b11100, 2'b00, 16'h1234, 16'h1234, 16'h0000, 8'h00, 16'h0001);
    issue("seq_ne",      1'b1, 5'b11100, 2'b00, 16'h1234, 16'h1235, 16'h0000, 8'h00, 16'h0000);
    issue("slt_neg",     1'b1, 5'b11101, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 8'h00, 16'h0001);
    issue("slt_pos",     1'b1, 5'b11101, 2'b00, 16'h0001, 16'hFFFF, 16'h0000, 8'h00, 16'h0000);
    issue("sle_eq",      1'b1, 5'b11110, 2'b00, 16'h8000, 16'h8000, 16'h0000, 8'h00, 16'h0001);
    issue("bnez_zero",   1'b1, 5'b01100, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000);
    issue("beqz_zero",   1'b1, 5'b01101, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0001);
    issue("bltz",        1'b1, 5'b01110, 2'b00, 16'h8000, 16'h0000, 16'h0000, 8'h00, 16'h0001);
    issue("bgez",        1'b1, 5'b01111, 2'b00, 16'h8000, 16'h0000, 16'h0000, 8'h00, 16'h0000);
    issue("lbi",         1'b1, 5'b11000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h80, 16'hFF80);
    issue("slbi",        1'b1, 5'b10010, 2'b00, 16'h12AB, 16'h0000, 16'h0000, 8'hCD, 16'hABCD);
    issue("jal",         1'b1, 5'b00110, 2'b00, 16'h5555, 16'h6666, 16'h1234, 8'h00, 16'h1234);
    issue("jalr",        1'b1, 5'b00111, 2'b00, 16'h5555, 16'h6666, 16'hBEEF, 8'h00, 16'hBEEF);
    issue("ld",          1'b1, 5'b10001, 2'b00, 16'h0100, 16'h0000, 16'h0000, 8'h10, 16'h00F0);
    issue("st",          1'b1, 5'b10000, 2'b00, 16'h0100, 16'h0000, 16'h0000, 8'h05, 16'h0105);
    issue("stu",         1'b1, 5'b10011, 2'b00, 16'h0000, 16'h0000, 16'h0000, 8'h1F, 16'hFFFF);
`ifdef ALU_BTR_EN
    issue("btr",         1'b1, 5'b11001, 2'b00, 16'h0001, 16'h0000, 16'h0000, 8'h00, 16'h8000);
`else
    issue("btr_off",     1'b1, 5'b11001, 2'b00, 16'h0001, 16'h0000, 16'h0000, 8'h00, 16'h0000);
`endif
    issue("unmapped",    1'b1, 5'b00000, 2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000);
    issue("pre_midrst",  1'b1, 5'b11011, 2'b00, 16'h1000, 16'h0234, 16'h0000, 8'h00, 16'h1234);
    issue("midrst",      1'b0, 5'b11011, 2'b00, 16'h1111, 16'h1111, 16'h0000, 8'h00, 16'h0000);
    issue("after_midrst",1'b1, 5'b11011, 2'b10, 16'h1111, 16'h0101, 16'h0000, 8'h00, 16'h1010);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
